// File: rtl/mem_arb_pkg.sv
// Shared definitions for the data-memory port arbiter: region bits, read-tracking states, counter width.
// Imported by the region decoder and the arbiter top.
package mem_arb_pkg;

    localparam int DMEM_BIT = 28;
    localparam int IMEM_BIT = 29;
    localparam int STARVE_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CORE_RD = 2'd1,
        LDR_RD  = 2'd2,
        NULL_RD = 2'd3
    } resp_state_e;

endpackage

// File: rtl/mem_region_decode.sv
// Address region decode: byte enables per memory plus a flag saying whether the access reaches a memory.
// Purely combinational, 0-cycle latency, no backpressure.
module mem_region_decode
    import mem_arb_pkg::*;
(
    input  logic [31:0] addr_i,
    input  logic [3:0]  we_i,
    output logic [3:0]  dmem_we_o,
    output logic [3:0]  imem_we_o,
    output logic        mapped_o
);

    logic is_wr;
    logic unused_addr;

    assign unused_addr = ^{addr_i[31:30], addr_i[27:0]};

    // IMEM is write-only, so a read only counts as mapped when it hits DMEM.
    always_comb begin
        is_wr     = |we_i;
        dmem_we_o = addr_i[DMEM_BIT] ? we_i : 4'h0;
        imem_we_o = addr_i[IMEM_BIT] ? we_i : 4'h0;
        mapped_o  = is_wr ? (addr_i[DMEM_BIT] | addr_i[IMEM_BIT]) : addr_i[DMEM_BIT];
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the DMEM/IMEM port between core and loader: core has priority, loader forced after STARVE_LIMIT denials.
// Grant and memory drive are same-cycle; read data returns exactly 1 cycle after the grant. Core stalls when denied.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 8,
    parameter int ADDR_W       = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_req,
    input  logic [3:0]        core_we,
    input  logic [31:0]       core_addr,
    input  logic [31:0]       core_wdata,
    output logic              core_stall,
    output logic              core_rvalid,
    output logic [31:0]       core_rdata,
    input  logic              ldr_valid,
    output logic              ldr_ready,
    input  logic [3:0]        ldr_we,
    input  logic [31:0]       ldr_addr,
    input  logic [31:0]       ldr_wdata,
    output logic              ldr_rvalid,
    output logic [31:0]       ldr_rdata,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [3:0]        dmem_we,
    output logic [3:0]        imem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       dmem_rdata
);

    localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

    resp_state_e         state_q, state_d;
    logic                null_ldr_q, null_ldr_d;
    logic [STARVE_W-1:0] starve_q, starve_d;

    logic        grant_ldr, grant_core, grant_any;
    logic [31:0] sel_addr;
    logic [3:0]  sel_we;
    logic        mapped;
    logic        unused_sel;

    assign grant_ldr  = ldr_valid && (!core_req || starve_q == LIMIT);
    assign grant_core = core_req && !grant_ldr;
    assign grant_any  = grant_ldr || grant_core;
    assign ldr_ready  = grant_ldr;
    assign core_stall = core_req && grant_ldr;

    // With no grant the core's address/data stay on the bus; enables are gated to zero.
    assign sel_addr  = grant_ldr ? ldr_addr  : core_addr;
    assign mem_wdata = grant_ldr ? ldr_wdata : core_wdata;
    assign sel_we    = grant_ldr ? ldr_we : (grant_core ? core_we : 4'h0);
    assign dmem_addr = sel_addr[ADDR_W+1:2];
    assign unused_sel = ^{sel_addr[31:ADDR_W+2], sel_addr[1:0]};

    mem_region_decode u_decode (
        .addr_i    (sel_addr),
        .we_i      (sel_we),
        .dmem_we_o (dmem_we),
        .imem_we_o (imem_we),
        .mapped_o  (mapped)
    );

    always_comb begin
        starve_d = starve_q;
        if (!ldr_valid || grant_ldr) begin
            starve_d = '0;
        end else if (starve_q != LIMIT) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            null_ldr_q <= 1'b0;
            starve_q   <= '0;
        end else begin
            state_q    <= state_d;
            null_ldr_q <= null_ldr_d;
            starve_q   <= starve_d;
        end
    end

    // Only the cycle's grant decides the next response owner; nothing carries over.
    always_comb begin
        state_d    = IDLE;
        null_ldr_d = 1'b0;
        if (grant_any && sel_we == 4'h0) begin
            null_ldr_d = grant_ldr;
            if (!mapped) begin
                state_d = NULL_RD;
            end else if (grant_ldr) begin
                state_d = LDR_RD;
            end else begin
                state_d = CORE_RD;
            end
        end
    end

    always_comb begin
        core_rvalid = 1'b0;
        ldr_rvalid  = 1'b0;
        core_rdata  = 32'h0;
        ldr_rdata   = 32'h0;
        case (state_q)
            CORE_RD: begin
                core_rvalid = 1'b1;
                core_rdata  = dmem_rdata;
            end
            LDR_RD: begin
                ldr_rvalid = 1'b1;
                ldr_rdata  = dmem_rdata;
            end
            NULL_RD: begin
                core_rvalid = !null_ldr_q;
                ldr_rvalid  = null_ldr_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter against a cycle-level reference model.
module tb_mem_port_arbiter;

    localparam int LIMIT  = 8;
    localparam int ADDR_W = 14;

    logic              clk = 1'b0;
    logic              rst;
    logic              core_req;
    logic [3:0]        core_we;
    logic [31:0]       core_addr;
    logic [31:0]       core_wdata;
    logic              core_stall;
    logic              core_rvalid;
    logic [31:0]       core_rdata;
    logic              ldr_valid;
    logic              ldr_ready;
    logic [3:0]        ldr_we;
    logic [31:0]       ldr_addr;
    logic [31:0]       ldr_wdata;
    logic              ldr_rvalid;
    logic [31:0]       ldr_rdata;
    logic [ADDR_W-1:0] dmem_addr;
    logic [3:0]        dmem_we;
    logic [3:0]        imem_we;
    logic [31:0]       mem_wdata;
    logic [31:0]       dmem_rdata;

    int passed = 0;
    int total  = 0;

    // Reference model state
    int          m_starve;
    bit          m_pend;
    bit          m_pend_ldr;
    logic [31:0] m_pend_data;

    always #5 clk = ~clk;

    mem_port_arbiter #(.STARVE_LIMIT(LIMIT), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_stall(core_stall), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
        .ldr_valid(ldr_valid), .ldr_ready(ldr_ready), .ldr_we(ldr_we), .ldr_addr(ldr_addr),
        .ldr_wdata(ldr_wdata), .ldr_rvalid(ldr_rvalid), .ldr_rdata(ldr_rdata),
        .dmem_addr(dmem_addr), .dmem_we(dmem_we), .imem_we(imem_we), .mem_wdata(mem_wdata),
        .dmem_rdata(dmem_rdata)
    );

    function automatic logic [31:0] word_of(input logic [ADDR_W-1:0] a);
        return {a, 2'b01, ~a, 2'b10};
    endfunction

    // BRAM stand-in: read data is a fixed function of last cycle's address.
    always @(posedge clk) dmem_rdata <= word_of(dmem_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // One clock: drive inputs after the edge, check at the falling edge, advance the model.
    task automatic step(input bit cr, input logic [3:0] cwe, input logic [31:0] ca, input logic [31:0] cd,
                        input bit lv, input logic [3:0] lwe, input logic [31:0] la, input logic [31:0] ld);
        bit          g_ldr, g_core;
        logic [31:0] a, d;
        logic [3:0]  we;
        bit          rd_hit;
        @(posedge clk);
        #1;
        core_req = cr; core_we = cwe; core_addr = ca; core_wdata = cd;
        ldr_valid = lv; ldr_we = lwe; ldr_addr = la; ldr_wdata = ld;
        g_ldr  = lv && (!cr || m_starve == LIMIT);
        g_core = cr && !g_ldr;
        a  = g_ldr ? la : ca;
        d  = g_ldr ? ld : cd;
        we = g_ldr ? lwe : (g_core ? cwe : 4'h0);
        @(negedge clk);
        chk("ldr_ready", 32'(ldr_ready), 32'(g_ldr));
        chk("core_stall", 32'(core_stall), 32'(cr && g_ldr));
        chk("dmem_addr", 32'(dmem_addr), 32'(a[ADDR_W+1:2]));
        chk("mem_wdata", mem_wdata, d);
        chk("dmem_we", 32'(dmem_we), a[28] ? 32'(we) : 32'h0);
        chk("imem_we", 32'(imem_we), a[29] ? 32'(we) : 32'h0);
        chk("core_rvalid", 32'(core_rvalid), 32'(m_pend && !m_pend_ldr));
        chk("ldr_rvalid", 32'(ldr_rvalid), 32'(m_pend && m_pend_ldr));
        chk("core_rdata", core_rdata, (m_pend && !m_pend_ldr) ? m_pend_data : 32'h0);
        chk("ldr_rdata", ldr_rdata, (m_pend && m_pend_ldr) ? m_pend_data : 32'h0);
        if (!lv || g_ldr) m_starve = 0;
        else if (m_starve < LIMIT) m_starve++;
        rd_hit      = (g_ldr || g_core) && we == 4'h0;
        m_pend      = rd_hit;
        m_pend_ldr  = g_ldr;
        m_pend_data = a[28] ? word_of(a[ADDR_W+1:2]) : 32'h0;
    endtask

    task automatic idle();
        step(0, 4'h0, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        core_req = 0; core_we = 0; core_addr = 0; core_wdata = 0;
        ldr_valid = 0; ldr_we = 0; ldr_addr = 0; ldr_wdata = 0;
        m_starve = 0; m_pend = 0; m_pend_ldr = 0; m_pend_data = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset core_rvalid", 32'(core_rvalid), 32'h0);
        chk("reset ldr_rvalid", 32'(ldr_rvalid), 32'h0);
        chk("reset core_rdata", core_rdata, 32'h0);
        chk("reset ldr_rdata", ldr_rdata, 32'h0);
        rst = 1'b0;

        // Core write, loader idle
        step(1, 4'hF, 32'h1000_0010, 32'hDEADBEEF, 0, 4'h0, 32'h0, 32'h0);
        chk("tp1 dmem_addr", 32'(dmem_addr), 32'd4);
        chk("tp1 dmem_we", 32'(dmem_we), 32'hF);
        // Loader write to both memories, core idle
        step(0, 4'h0, 32'h0, 32'h0, 1, 4'hF, 32'h3000_0008, 32'h1234_5678);
        chk("tp2 imem_we", 32'(imem_we), 32'hF);
        chk("tp2 dmem_addr", 32'(dmem_addr), 32'd2);

        // Starvation: both held; loader forced in on every 9th cycle
        for (int c = 1; c <= 27; c++) begin
            step(1, 4'h0, 32'h1000_0100, 32'h0, 1, 4'h0, 32'h1000_0200, 32'h0);
            chk("starve pattern", 32'(ldr_ready), 32'(c % (LIMIT + 1) == 0));
        end
        idle();

        // Read routing: core read then loader read
        step(1, 4'h0, 32'h1000_0000, 32'h0, 0, 4'h0, 32'h0, 32'h0);
        step(0, 4'h0, 32'h0, 32'h0, 1, 4'h0, 32'h1000_0004, 32'h0);
        chk("route core word0", core_rdata, word_of(14'd0));
        idle();
        chk("route ldr word1", ldr_rdata, word_of(14'd1));
        chk("route no crosstalk", core_rdata, 32'h0);

        // Unmapped loader read
        step(0, 4'h0, 32'h0, 32'h0, 1, 4'h0, 32'h0000_0040, 32'h0);
        chk("unmapped we", 32'({dmem_we, imem_we}), 32'h0);
        idle();
        chk("unmapped rvalid", 32'(ldr_rvalid), 32'h1);

        // Build up starvation, then reset mid-read
        for (int c = 0; c < 5; c++)
            step(1, 4'hF, 32'h1000_0020, 32'h0, 1, 4'hF, 32'h1000_0030, 32'h0);
        step(1, 4'h0, 32'h1000_0008, 32'h0, 0, 4'h0, 32'h0, 32'h0);
        rst = 1'b1;
        m_pend = 0; m_starve = 0;
        @(posedge clk);
        #1;
        core_req = 0;
        @(negedge clk);
        chk("reset-mid-read core_rvalid", 32'(core_rvalid), 32'h0);
        rst = 1'b0;
        for (int c = 1; c <= LIMIT + 1; c++) begin
            step(1, 4'h0, 32'h1000_0100, 32'h0, 1, 4'h0, 32'h1000_0200, 32'h0);
            chk("post-reset starve", 32'(ldr_ready), 32'(c == LIMIT + 1));
        end

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            logic [31:0] ca, la;
            logic [3:0]  cwe, lwe;
            ca  = {2'b00, 2'($urandom_range(0, 3)), 12'h0, 14'($urandom), 2'b00};
            la  = {2'b00, 2'($urandom_range(0, 3)), 12'h0, 14'($urandom), 2'b00};
            cwe = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            lwe = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            step($urandom_range(0, 9) < 7, cwe, ca, $urandom,
                 $urandom_range(0, 9) < 5, lwe, la, $urandom);
        end
        idle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
